// File: rtl/dso_spi_pkg.sv
// Shared definitions for the calibration EEPROM SPI responder:
// opcodes, frame width, FSM state encodings and the store reset value.
package dso_spi_pkg;

    localparam int         FRAME_W     = 16;
    localparam logic [1:0] OP_READ     = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [7:0] RST_VAL     = 8'h80;
    localparam logic [4:0] BIT_CNT_MAX = 5'd17;
    localparam logic [4:0] BIT_CNT_OK  = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        EXEC  = 2'b10
    } state_t;

endpackage

// File: rtl/eep_regfile.sv
// Calibration store: 2**ADDR_W x 8 flops, async reset to RST_VAL,
// one synchronous write port and one combinational read port.
module eep_regfile #(
    parameter int         ADDR_W  = 6,
    parameter logic [7:0] RST_VAL = dso_spi_pkg::RST_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    // Store array: every entry returns to RST_VAL on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_cal_eep_slave.sv
// SPI responder emulating the calibration EEPROM (16-bit mode-0 frames
// {op[1:0], addr[5:0], data[7:0]}). All SPI pins are oversampled in clk.
// Build option: define EEP_WRT_PROT_EN to make wp_n==0 reject WRITE frames.
//
// state | meaning
// IDLE  | waiting for SS_n fall, MISO held low
// SHIFT | frame in progress, sampling MOSI on SCLK rise, shifting MISO on fall
// EXEC  | one clock: frame executed or rejected, done/err pulse issued
module spi_cal_eep_slave #(
    parameter int         ADDR_W  = 6,
    parameter logic [7:0] RST_VAL = dso_spi_pkg::RST_VAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO,
    input  logic wp_n,
    output logic frm_done,
    output logic frm_err
);

    import dso_spi_pkg::*;

    logic ss_s1, ss_s2, ss_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    state_t               state;
    logic [FRAME_W-1:0]   rx_sr;
    // Bits still to be sent after the one currently on MISO.
    logic [FRAME_W-2:0]   tx_sr;
    logic [4:0]           bit_cnt;
    logic [7:0]           rd_buf;
    logic [7:0]           rd_buf_nxt;

    logic [1:0]           op;
    logic [ADDR_W-1:0]    addr;
    logic [7:0]           wdata;
    logic [7:0]           rdata;
    logic                 frame_ok;
    logic                 is_read;
    logic                 is_write;
    logic                 wr_allow;
    logic                 we;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ss_fall   =  ss_d   & ~ss_s2;
    assign ss_rise   = ~ss_d   &  ss_s2;
    assign sclk_rise = ~sclk_d &  sclk_s2;
    assign sclk_fall =  sclk_d & ~sclk_s2;

    assign op       = rx_sr[15:14];
    assign addr     = rx_sr[8 +: ADDR_W];
    assign wdata    = rx_sr[7:0];
    assign frame_ok = (bit_cnt == BIT_CNT_OK);
    assign is_read  = frame_ok && (op == OP_READ);
    assign is_write = frame_ok && (op == OP_WRITE);

`ifdef EEP_WRT_PROT_EN
    assign wr_allow = wp_n;
`else
    // Write protect pin has no effect in this build.
    assign wr_allow = wp_n | 1'b1;
`endif

    assign we         = (state == EXEC) && is_write && wr_allow;
    assign rd_buf_nxt = ((state == EXEC) && is_read) ? rdata : rd_buf;

    eep_regfile #(
        .ADDR_W  (ADDR_W),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (addr),
        .wdata (wdata),
        .raddr (addr),
        .rdata (rdata)
    );

    // Frame FSM: shift registers, bit counter, read buffer and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx_sr    <= '0;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            rd_buf   <= RST_VAL;
            MISO     <= 1'b0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        // High byte of every returned frame is zero, so the
                        // first MISO bit is already correct at 0.
                        state   <= SHIFT;
                        tx_sr   <= {{(FRAME_W-9){1'b0}}, rd_buf};
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= EXEC;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[FRAME_W-2:0], mosi_s2};
                            if (bit_cnt != BIT_CNT_MAX) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            MISO  <= tx_sr[FRAME_W-2];
                            tx_sr <= {tx_sr[FRAME_W-3:0], 1'b0};
                        end
                    end
                end
                EXEC: begin
                    MISO   <= 1'b0;
                    rd_buf <= rd_buf_nxt;
                    if (frame_ok && !(is_write && !wr_allow)) begin
                        frm_done <= 1'b1;
                    end else begin
                        frm_err <= 1'b1;
                    end
                    // A new frame may already be starting if SS_n bounced
                    // inside the synchronizer window; it must see the
                    // freshly updated read buffer.
                    if (ss_fall) begin
                        state   <= SHIFT;
                        tx_sr   <= {{(FRAME_W-9){1'b0}}, rd_buf_nxt};
                        bit_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    MISO  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cal_eep_slave.sv
// Directed bench for spi_cal_eep_slave: acts as the SPI master (SCLK = clk/16),
// checks returned frames and frm_done / frm_err pulse counts.
module tb_spi_cal_eep_slave;

    logic clk;
    logic rst_n;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic wp_n;
    logic frm_done;
    logic frm_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    spi_cal_eep_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .wp_n     (wp_n),
        .frm_done (frm_done),
        .frm_err  (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the single-cycle status outputs.
    always @(negedge clk) begin
        if (frm_done === 1'b1) done_cnt++;
        if (frm_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) MOSI = word[15-i];
            else        MOSI = 1'b0;
            repeat (8) @(negedge clk);
            rx   = {rx[14:0], MISO};
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [15:0] word, input int nbits,
                            input logic [15:0] exp_rx, input int exp_done, input int exp_err);
        logic [15:0] rx;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(word, nbits, rx);
        if (nbits == 16) chk({tag, ".rx"}, {16'h0, rx}, {16'h0, exp_rx});
        chk({tag, ".done"}, done_cnt - d0, exp_done);
        chk({tag, ".err"}, err_cnt - e0, exp_err);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] abort_word;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        wp_n  = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst.miso", {31'h0, MISO}, 32'h0);
        chk("rst.done", {31'h0, frm_done}, 32'h0);
        chk("rst.err", {31'h0, frm_err}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write then read-back with one frame of latency.
        do_frame("wr05",   16'h45A5, 16, 16'h0080, 1, 0);
        do_frame("rd05",   16'h0500, 16, 16'h0080, 1, 0);
        do_frame("nop05",  16'h0000, 16, 16'h00A5, 1, 0);

        // Read of the last address right after reset contents.
        do_frame("rd3f",   16'h3F00, 16, 16'h0080, 1, 0);
        do_frame("nop3f",  16'h0000, 16, 16'h0080, 1, 0);

        // Short frame: rejected, store untouched.
        do_frame("short",  16'h4A3C,  9, 16'h0000, 0, 1);
        do_frame("rd0a",   16'h0A00, 16, 16'h0080, 1, 0);
        do_frame("nop0a",  16'h0000, 16, 16'h0080, 1, 0);

        // Long frame: rejected, store untouched.
        do_frame("long",   16'h4A3C, 17, 16'h0000, 0, 1);
        do_frame("rd0a_b", 16'h0A00, 16, 16'h0080, 1, 0);
        do_frame("nop0a_b",16'h0000, 16, 16'h0080, 1, 0);

        // Load rd_buf with 0xFF so MISO is high mid-frame, then abort by reset.
        do_frame("wr07",   16'h47FF, 16, 16'h0080, 1, 0);
        do_frame("rd07",   16'h0700, 16, 16'h0080, 1, 0);
        do_frame("wr12",   16'h5233, 16, 16'h00FF, 1, 0);

        abort_word = 16'h525A;
        rx = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i <= 12; i++) begin
            MOSI = abort_word[15-i];
            repeat (8) @(negedge clk);
            rx   = {rx[14:0], MISO};
            SCLK = 1'b1;
            if (i < 12) begin
                repeat (8) @(negedge clk);
                SCLK = 1'b0;
            end
        end
        chk("abort.rx13", {19'h0, rx[12:0]}, 32'h0000_001F);
        chk("abort.miso_pre", {31'h0, MISO}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort.miso_rst", {31'h0, MISO}, 32'h0);
        SCLK = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_frame("rd12",   16'h1200, 16, 16'h0080, 1, 0);
        do_frame("nop12",  16'h0000, 16, 16'h0080, 1, 0);

        // Reserved opcode 2'b11 changes neither store nor rd_buf.
        do_frame("wr20",   16'h60C3, 16, 16'h0080, 1, 0);
        do_frame("rd20",   16'h2000, 16, 16'h0080, 1, 0);
        do_frame("op11",   16'hE011, 16, 16'h00C3, 1, 0);
        do_frame("rd20_b", 16'h2000, 16, 16'h00C3, 1, 0);
        do_frame("nop20",  16'hC000, 16, 16'h00C3, 1, 0);

        // Write protect.
        wp_n = 1'b0;
`ifdef EEP_WRT_PROT_EN
        do_frame("wp_wr01", 16'h41FF, 16, 16'h00C3, 0, 1);
        do_frame("wp_rd01", 16'h0100, 16, 16'h00C3, 1, 0);
        do_frame("wp_nop",  16'hC000, 16, 16'h0080, 1, 0);
        wp_n = 1'b1;
        do_frame("wr01",    16'h41FF, 16, 16'h0080, 1, 0);
        do_frame("rd01",    16'h0100, 16, 16'h0080, 1, 0);
        do_frame("nop01",   16'hC000, 16, 16'h00FF, 1, 0);
`else
        do_frame("wp_wr01", 16'h41FF, 16, 16'h00C3, 1, 0);
        do_frame("wp_rd01", 16'h0100, 16, 16'h00C3, 1, 0);
        do_frame("wp_nop",  16'hC000, 16, 16'h00FF, 1, 0);
        wp_n = 1'b1;
`endif

        chk("idle.miso", {31'h0, MISO}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
